// File: rtl/axi_chan_fifo.sv
// Parametrised valid/ready FIFO for AXI channel queues with optional output register,
// occupancy count, almost-full/almost-empty flags, synchronous flush and high-water mark.
module axi_chan_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int OUT_REG   = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int CNT_W     = $clog2(DEPTH + 2)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] hwm,
    input  logic             hwm_clr
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CAP = DEPTH + OUT_REG;

    localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [AW:0]      PTR_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]      PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] hwm_q, hwm_d;

    logic             push_s;
    logic             pop_s;
    logic             mem_empty_s;
    logic             mem_wr_s;
    logic             mem_rd_s;
    logic             wr_ready_s;
    logic             rd_valid_s;
    logic [WIDTH-1:0] mem_head_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    rd_idx_s;

    // Extra pointer MSB distinguishes full from empty without a separate flag.
    assign wr_idx_s    = wr_ptr_q[AW-1:0];
    assign rd_idx_s    = rd_ptr_q[AW-1:0];
    assign mem_empty_s = (wr_ptr_q == rd_ptr_q);
    assign mem_head_s  = mem_q[rd_idx_s];

    // wr_ready depends only on the registered count, so a full FIFO never accepts on a pop.
    assign wr_ready_s = (count_q != CAP_C);
    assign push_s     = wr_valid & wr_ready_s;
    assign pop_s      = rd_valid_s & rd_ready;

    generate
        if (OUT_REG == 0) begin : g_direct
            assign mem_wr_s   = push_s;
            assign mem_rd_s   = pop_s;
            assign rd_valid_s = !mem_empty_s;
            // Gate the head so unwritten memory never reaches the output.
            assign rd_data    = rd_valid_s ? mem_head_s : DATA_ZERO;
        end else begin : g_outreg
            logic             out_valid_q, out_valid_d;
            logic [WIDTH-1:0] out_data_q, out_data_d;
            logic             load_s;
            logic             bypass_s;

            // Refill the output register whenever it is free or draining; an empty memory
            // lets the incoming beat skip straight into the register.
            always_comb begin
                load_s      = (!out_valid_q || pop_s) && (!mem_empty_s || push_s);
                bypass_s    = load_s && mem_empty_s && push_s;
                out_valid_d = out_valid_q;
                out_data_d  = out_data_q;
                if (flush) begin
                    out_valid_d = 1'b0;
                    out_data_d  = DATA_ZERO;
                end else if (load_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bypass_s ? wr_data : mem_head_s;
                end else if (pop_s) begin
                    out_valid_d = 1'b0;
                    out_data_d  = out_data_q;
                end else begin
                    out_valid_d = out_valid_q;
                    out_data_d  = out_data_q;
                end
            end

            // Output register state.
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= DATA_ZERO;
                end else begin
                    out_valid_q <= out_valid_d;
                    out_data_q  <= out_data_d;
                end
            end

            assign mem_wr_s   = push_s && !bypass_s;
            assign mem_rd_s   = load_s && !mem_empty_s;
            assign rd_valid_s = out_valid_q;
            assign rd_data    = out_data_q;
        end
    endgenerate

    // Next-state for pointers, occupancy and high-water mark; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hwm_d    = hwm_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
            hwm_d    = CNT_ZERO;
        end else begin
            wr_ptr_d = mem_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            rd_ptr_d = mem_rd_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            if (push_s && !pop_s) begin
                count_d = count_q + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
            if (hwm_clr) begin
                hwm_d = count_d;
            end else if (count_d > hwm_q) begin
                hwm_d = count_d;
            end else begin
                hwm_d = hwm_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            hwm_q    <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Payload storage; contents are deliberately not reset.
    always_ff @(posedge aclk) begin
        if (mem_wr_s && !flush) begin
            mem_q[wr_idx_s] <= wr_data;
        end
    end

    assign wr_ready     = wr_ready_s;
    assign rd_valid     = rd_valid_s;
    assign count        = count_q;
    assign hwm          = hwm_q;
    assign almost_full  = (int'(count_q) >= AF_THRESH);
    assign almost_empty = (int'(count_q) <= AE_THRESH);

endmodule

// File: tb/tb_axi_chan_fifo.sv
// Scoreboard bench for axi_chan_fifo: three configurations share one random/directed
// stimulus stream; each has its own queue-based reference model and monitor.
module tb_axi_chan_fifo;

    localparam int W = 8;

    logic         aclk     = 1'b0;
    logic         aresetn  = 1'b0;
    logic         flush    = 1'b0;
    logic         wr_valid = 1'b0;
    logic         rd_ready = 1'b0;
    logic         hwm_clr  = 1'b0;
    logic [W-1:0] wr_data  = 8'h00;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // cfg0: DEPTH=4 direct, cfg1: DEPTH=4 output register, cfg2: DEPTH=2 with constant flags.
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int D   = (g == 2) ? 2 : 4;
        localparam int OR  = (g == 1) ? 1 : 0;
        localparam int AF  = (g == 2) ? 0 : D - 2;
        localparam int AE  = (g == 2) ? -1 : 1;
        localparam int CW  = $clog2(D + 2);
        localparam int CAP = D + OR;

        logic          wr_ready, rd_valid, almost_full, almost_empty;
        logic [W-1:0]  rd_data;
        logic [CW-1:0] count, hwm;

        axi_chan_fifo #(
            .WIDTH(W), .DEPTH(D), .OUT_REG(OR),
            .AF_THRESH(AF), .AE_THRESH(AE), .CNT_W(CW)
        ) u_dut (
            .aclk(aclk), .aresetn(aresetn), .flush(flush),
            .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
            .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
            .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
            .hwm(hwm), .hwm_clr(hwm_clr)
        );

        logic [W-1:0] sbq [$];
        int           hwm_m = 0;

        // Monitor: compare against the model state, then advance the model by the
        // operations the upcoming rising edge will perform.
        always @(negedge aclk) begin
            int sz;
            bit push_m;
            if (!aresetn) begin
                sbq.delete();
                hwm_m = 0;
            end
            sz = sbq.size();
            chk($sformatf("cfg%0d count", g), int'(count), sz);
            chk($sformatf("cfg%0d rd_valid", g), int'(rd_valid), int'(sz != 0));
            chk($sformatf("cfg%0d wr_ready", g), int'(wr_ready), int'(sz != CAP));
            chk($sformatf("cfg%0d almost_full", g), int'(almost_full), int'(sz >= AF));
            chk($sformatf("cfg%0d almost_empty", g), int'(almost_empty), int'(sz <= AE));
            chk($sformatf("cfg%0d hwm", g), int'(hwm), hwm_m);
            if (rd_valid && sz != 0) begin
                chk($sformatf("cfg%0d rd_data", g), int'(rd_data), int'(sbq[0]));
            end
            if (aresetn) begin
                push_m = wr_valid && (sz != CAP);
                if (flush) begin
                    sbq.delete();
                    hwm_m = 0;
                end else begin
                    if (rd_valid && rd_ready) begin
                        if (sz == 0) begin
                            chk($sformatf("cfg%0d pop_from_empty", g), 1, 0);
                        end else begin
                            void'(sbq.pop_front());
                        end
                    end
                    if (push_m) sbq.push_back(wr_data);
                    if (hwm_clr) hwm_m = sbq.size();
                    else if (sbq.size() > hwm_m) hwm_m = sbq.size();
                end
            end
        end

        // Asynchronous reset must clear outputs without waiting for a clock edge.
        always @(negedge aresetn) begin
            #1;
            if (!aresetn) begin
                chk($sformatf("cfg%0d async count", g), int'(count), 0);
                chk($sformatf("cfg%0d async rd_valid", g), int'(rd_valid), 0);
                chk($sformatf("cfg%0d async wr_ready", g), int'(wr_ready), 1);
                chk($sformatf("cfg%0d async rd_data", g), int'(rd_data), 0);
                chk($sformatf("cfg%0d async hwm", g), int'(hwm), 0);
                chk($sformatf("cfg%0d async almost_full", g), int'(almost_full), int'(AF <= 0));
                chk($sformatf("cfg%0d async almost_empty", g), int'(almost_empty), int'(AE >= 0));
            end
        end
    end

    task automatic cyc(input bit wv, input logic [W-1:0] wd, input bit rr,
                       input bit fl, input bit hc);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        hwm_clr  = hc;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill past capacity with the consumer stalled, then drain.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0);
        repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Sustained streaming.
        for (int i = 0; i < 100; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Random traffic with backpressure, occasional hwm clears and flushes.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
        end
        repeat (8) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with contents plus a concurrent push and pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle with two beats stored.
        cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        wr_valid = 1'b0;
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
